// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the 4-bit CPU fetch/execute sequencer: state encoding and
// instruction field helpers used by the sequencer and anything decoding its IR.
package cpu_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } seq_state_e;

  localparam int OP_WIDTH  = 4;
  localparam int IMM_WIDTH = 4;

  function automatic logic [OP_WIDTH-1:0] inst_op(input logic [7:0] inst);
    return inst[7:4];
  endfunction

  function automatic logic [IMM_WIDTH-1:0] inst_imm(input logic [7:0] inst);
    return inst[3:0];
  endfunction

endpackage

// File: rtl/cpu_sequencer_prog_rom.sv
// Program memory: synchronous write, asynchronous read, contents survive reset
// so a loaded program can be re-run after the sequencer is reset.
module cpu_sequencer_prog_rom #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer: owns program memory and the instruction register,
// gates datapath commits with exec_en, and handles run/step/breakpoint control.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int PC_WIDTH   = 4,
  parameter int INST_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  step,
  input  logic                  bp_en,
  input  logic [PC_WIDTH-1:0]   bp_addr,
  input  logic [PC_WIDTH-1:0]   pc_in,
  input  logic                  prog_wr_valid,
  output logic                  prog_wr_ready,
  input  logic [PC_WIDTH-1:0]   prog_wr_addr,
  input  logic [INST_WIDTH-1:0] prog_wr_data,
  output logic [3:0]            op_out,
  output logic [3:0]            imm_out,
  output logic                  exec_en,
  output logic                  halted,
  output logic                  bp_hit,
  output logic [CNT_WIDTH-1:0]  retired
);

  seq_state_e            state_q, state_d;
  logic [INST_WIDTH-1:0] ir_q, ir_d;
  logic                  resume_q, resume_d;
  logic                  single_q, single_d;
  logic                  bp_hit_q, bp_hit_d;
  logic [CNT_WIDTH-1:0]  retired_q, retired_d;
  logic [INST_WIDTH-1:0] rom_data;
  logic                  rom_wr_en;

  assign rom_wr_en = prog_wr_valid && (state_q == ST_IDLE);

  cpu_sequencer_prog_rom #(
    .ADDR_WIDTH (PC_WIDTH),
    .DATA_WIDTH (INST_WIDTH)
  ) u_prog_rom (
    .clk     (clk),
    .wr_en   (rom_wr_en),
    .wr_addr (prog_wr_addr),
    .wr_data (prog_wr_data),
    .rd_addr (pc_in),
    .rd_data (rom_data)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    resume_d  = resume_q;
    single_d  = single_q;
    bp_hit_d  = bp_hit_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE: begin
        if (run || step) begin
          state_d  = ST_FETCH;
          resume_d = 1'b1;
          single_d = !run;
          bp_hit_d = 1'b0;
        end
      end
      ST_FETCH: begin
        // resume guarantees the first fetch after leaving IDLE can pass a breakpoint
        if (bp_en && (pc_in == bp_addr) && !resume_q) begin
          state_d  = ST_IDLE;
          bp_hit_d = 1'b1;
        end else begin
          ir_d     = rom_data;
          resume_d = 1'b0;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        retired_d = retired_q + CNT_WIDTH'(1);
        state_d   = (single_q || !run) ? ST_IDLE : ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      resume_q  <= 1'b0;
      single_q  <= 1'b0;
      bp_hit_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      resume_q  <= resume_d;
      single_q  <= single_d;
      bp_hit_q  <= bp_hit_d;
      retired_q <= retired_d;
    end
  end

  assign op_out        = inst_op(ir_q[7:0]);
  assign imm_out       = inst_imm(ir_q[7:0]);
  assign exec_en       = (state_q == ST_EXEC);
  assign halted        = (state_q == ST_IDLE);
  assign prog_wr_ready = (state_q == ST_IDLE);
  assign bp_hit        = bp_hit_q;
  assign retired       = retired_q;

endmodule
